// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the seven-segment scan driver.
//   PWM_STEPS      : PWM phases per digit slot (the 16th is always dark)
//   seg_t          : 8-bit segment bus {a,b,c,d,e,f,g,dp}
//   SEG_0..SEG_F   : 7-bit {a..g} patterns for the hex digits 0..F
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    localparam int PWM_STEPS = 16;

    typedef logic [7:0] seg_t;

    // {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Purely combinational hex-to-seven-segment decoder.
//   nibble  in  4  hex digit 0..F
//   pattern out 7  {a,b,c,d,e,f,g}, active-high
// -----------------------------------------------------------------------------
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_0;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            default: pattern = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
// with PWM brightness, per-digit dp/blank and a double-buffered display value
// that only changes at frame boundaries.
//
// Parameters
//   NUM_DIGITS  digits scanned (1..16)
//   DIV         clk cycles per PWM phase (>=1); one digit slot = 16*DIV cycles
// Ports
//   clk         system clock, posedge
//   rst_n       synchronous active-low reset
//   value       4*NUM_DIGITS hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp          per-digit decimal point, captured on load
//   blank       per-digit force-dark, captured on load
//   load        one-cycle strobe capturing value/dp/blank
//   brightness  duty 0..15 (phases lit per 16), sampled live
//   an          anode enables, active-low
//   segs        {a,b,c,d,e,f,g,dp}, active-high
//   frame_tick  one-cycle pulse after each frame boundary
//
// Build option: define LEAD_ZERO_BLANK_EN to darken leading zero digits
// (digit 0 always shown; a dp on a digit stops suppression at and below it).
// -----------------------------------------------------------------------------
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 25000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              segs,
    output logic                    frame_tick
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PH_W  = $clog2(PWM_STEPS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    // Counter state
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    // Shadow (staging) and display registers
    logic [VAL_W-1:0]      shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q,    shadow_dp_d;
    logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
    logic                  pending_q,      pending_d;
    logic [VAL_W-1:0]      disp_value_q,   disp_value_d;
    logic [NUM_DIGITS-1:0] disp_dp_q,      disp_dp_d;
    logic [NUM_DIGITS-1:0] disp_blank_q,   disp_blank_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0] an_q,         an_d;
    seg_t                  segs_q,       segs_d;
    logic                  frame_tick_q, frame_tick_d;

    logic phase_step;
    logic slot_end;
    logic frame_end;

    // ---------------------------------------------------------------- counters
    always_comb begin
        phase_step = (pre_q == PRE_W'(DIV - 1));
        slot_end   = phase_step && (phase_q == PH_W'(PWM_STEPS - 1));
        frame_end  = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

        pre_d   = phase_step ? '0 : pre_q + 1'b1;
        phase_d = phase_q;
        if (slot_end) begin
            phase_d = '0;
        end else if (phase_step) begin
            phase_d = phase_q + 1'b1;
        end
        idx_d = idx_q;
        if (frame_end) begin
            idx_d = '0;
        end else if (slot_end) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // ----------------------------------------------------------- double buffer
    // A load coinciding with frame_end bypasses the shadow and lands directly
    // in the display register, so nothing is left pending.
    always_comb begin
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        pending_d      = pending_q;
        disp_value_d   = disp_value_q;
        disp_dp_d      = disp_dp_q;
        disp_blank_d   = disp_blank_q;

        if (load) begin
            shadow_value_d = value;
            shadow_dp_d    = dp;
            shadow_blank_d = blank;
        end

        if (frame_end) begin
            pending_d = 1'b0;
            if (load) begin
                disp_value_d = value;
                disp_dp_d    = dp;
                disp_blank_d = blank;
            end else if (pending_q) begin
                disp_value_d = shadow_value_q;
                disp_dp_d    = shadow_dp_q;
                disp_blank_d = shadow_blank_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // ---------------------------------------------------- leading-zero blanking
    logic [NUM_DIGITS-1:0] lz_dark;

`ifdef LEAD_ZERO_BLANK_EN
    // keep[i] is set once any digit at or above i is non-zero or carries a dp;
    // digit 0 is always kept.
    logic [NUM_DIGITS:0] lz_keep;
    assign lz_keep[NUM_DIGITS] = 1'b0;
    for (genvar gi = NUM_DIGITS - 1; gi >= 0; gi--) begin : g_lz
        assign lz_keep[gi] = lz_keep[gi+1]
                           | (disp_value_q[4*gi +: 4] != 4'h0)
                           | disp_dp_q[gi]
                           | (gi == 0);
        assign lz_dark[gi] = ~lz_keep[gi];
    end
`else
    assign lz_dark = '0;
`endif

    // ------------------------------------------------------ active-digit path
    logic [3:0] act_nibble;
    logic       act_dp;
    logic       act_blank;
    logic       act_lz;
    logic       lit;
    logic [6:0] act_pattern;

    // Mux by comparison rather than by index so idx never addresses a
    // non-existent digit when NUM_DIGITS is not a power of two.
    always_comb begin
        act_nibble = '0;
        act_dp     = 1'b0;
        act_blank  = 1'b0;
        act_lz     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                act_nibble = disp_value_q[4*i +: 4];
                act_dp     = disp_dp_q[i];
                act_blank  = disp_blank_q[i];
                act_lz     = lz_dark[i];
            end
        end
        lit = (phase_q < brightness) && !act_blank && !act_lz;
    end

    seg_hex_decode u_decode (
        .nibble  (act_nibble),
        .pattern (act_pattern)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
        assign an_d[gi] = ~(lit && (idx_q == IDX_W'(gi)));
    end

    always_comb begin
        segs_d       = lit ? {act_pattern, act_dp} : '0;
        frame_tick_d = frame_end;
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q          <= '0;
            phase_q        <= '0;
            idx_q          <= '0;
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            pending_q      <= 1'b0;
            disp_value_q   <= '0;
            disp_dp_q      <= '0;
            disp_blank_q   <= '0;
            an_q           <= '1;
            segs_q         <= '0;
            frame_tick_q   <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            phase_q        <= phase_d;
            idx_q          <= idx_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            pending_q      <= pending_d;
            disp_value_q   <= disp_value_d;
            disp_dp_q      <= disp_dp_d;
            disp_blank_q   <= disp_blank_d;
            an_q           <= an_d;
            segs_q         <= segs_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign segs       = segs_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
// Directed bench for seg_scan_mux (NUM_DIGITS=4, DIV=2). A cycle-count based
// reference model pushes the expected an/segs/frame_tick for every clock edge
// into a queue; a negedge monitor pops and compares. Directed steps add
// duty-cycle, frame-period and buffering checks with spec-derived constants.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

    localparam int N     = 4;
    localparam int D     = 2;
    localparam int SLOT  = 16 * D;
    localparam int FRAME = N * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] segs;
        logic       ft;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [15:0]   value;
    logic [3:0]    dp;
    logic [3:0]    blank;
    logic          load;
    logic [3:0]    brightness;
    logic [3:0]    an;
    logic [7:0]    segs;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    seg_scan_mux #(.NUM_DIGITS(N), .DIV(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .load       (load),
        .brightness (brightness),
        .an         (an),
        .segs       (segs),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: return 8'hFC;  4'h1: return 8'h60;  4'h2: return 8'hDA;  4'h3: return 8'hF2;
            4'h4: return 8'h66;  4'h5: return 8'hB6;  4'h6: return 8'hBE;  4'h7: return 8'hE0;
            4'h8: return 8'hFE;  4'h9: return 8'hF6;  4'hA: return 8'hEE;  4'hB: return 8'h3E;
            4'hC: return 8'h9C;  4'hD: return 8'h7A;  4'hE: return 8'h9E;  default: return 8'h8E;
        endcase
    endfunction

    // ------------------------------------------------------- reference model
    int          m_cnt;
    logic [15:0] m_val, m_sh_val;
    logic [3:0]  m_dp, m_blank, m_sh_dp, m_sh_blank;
    logic        m_pend;
    exp_t        exp_q[$];

    function automatic exp_t model_out(input int cnt, input logic [15:0] v,
                                       input logic [3:0] d, input logic [3:0] b,
                                       input logic [3:0] br);
        int   ph = (cnt / D) % 16;
        int   ix = (cnt / SLOT) % N;
        logic on;
        exp_t r;
        on = (ph < int'(br)) && !b[ix];
`ifdef LEAD_ZERO_BLANK_EN
        if (ix != 0) begin
            logic keep = 1'b0;
            for (int j = ix; j < N; j++) begin
                if (v[4*j +: 4] != 4'h0 || d[j]) keep = 1'b1;
            end
            if (!keep) on = 1'b0;
        end
`endif
        r.an   = 4'hF;
        r.segs = 8'h00;
        r.ft   = ((cnt % FRAME) == FRAME - 1);
        if (on) begin
            r.an[ix] = 1'b0;
            r.segs   = hex_pat(v[4*ix +: 4]) | {7'b0, d[ix]};
        end
        return r;
    endfunction

    function automatic logic model_frame_end(input int cnt);
        return (cnt % FRAME) == FRAME - 1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.push_back('{an: 4'hF, segs: 8'h00, ft: 1'b0});
            m_cnt      <= 0;
            m_val      <= '0;  m_dp    <= '0;  m_blank    <= '0;
            m_sh_val   <= '0;  m_sh_dp <= '0;  m_sh_blank <= '0;
            m_pend     <= 1'b0;
        end else begin
            exp_q.push_back(model_out(m_cnt, m_val, m_dp, m_blank, brightness));
            if (load) begin
                m_sh_val <= value; m_sh_dp <= dp; m_sh_blank <= blank;
                if (model_frame_end(m_cnt)) begin
                    m_val <= value; m_dp <= dp; m_blank <= blank;
                    m_pend <= 1'b0;
                end else begin
                    m_pend <= 1'b1;
                end
            end else if (model_frame_end(m_cnt) && m_pend) begin
                m_val <= m_sh_val; m_dp <= m_sh_dp; m_blank <= m_sh_blank;
                m_pend <= 1'b0;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("scan_an",   32'(an),         32'(mon_e.an));
            check("scan_segs", 32'(segs),       32'(mon_e.segs));
            check("scan_tick", 32'(frame_tick), 32'(mon_e.ft));
        end
    end

    // -------------------------------------------------------- directed helpers
    int low_cnt [N];
    int dp0_cnt;
    int nondark_cnt;

    task automatic wait_ft(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3 * FRAME && !ok; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ok = 1'b1;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    // Samples FRAME consecutive negedges starting at the current one.
    task automatic sample_frame();
        for (int k = 0; k < N; k++) low_cnt[k] = 0;
        dp0_cnt     = 0;
        nondark_cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            for (int k = 0; k < N; k++) begin
                if (an[k] === 1'b0) low_cnt[k]++;
            end
            if (an === 4'b1110 && segs[0] === 1'b1) dp0_cnt++;
            if (an !== 4'hF || segs !== 8'h00) nondark_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp = d; blank = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst_n = 1'b0; load = 1'b0; value = '0; dp = '0; blank = '0; brightness = 4'd15;
        repeat (3) @(negedge clk);
        check("reset_an",   32'(an),         32'hF);
        check("reset_segs", 32'(segs),       32'h0);
        check("reset_tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        $display("step: load 8421, brightness 15");
        do_load(16'h8421, 4'h0, 4'h0);
        wait_ft("first_frame_tick");
        sample_frame();
        for (int k = 0; k < N; k++) check("duty15_low_cycles", 32'(low_cnt[k]), 32'd30);
        check("frame_period", 32'(frame_tick), 32'd1);

        $display("step: brightness 4");
        brightness = 4'd4;
        sample_frame();
        for (int k = 0; k < N; k++) check("duty4_low_cycles", 32'(low_cnt[k]), 32'd8);

        $display("step: brightness 0");
        brightness = 4'd0;
        sample_frame();
        check("duty0_nondark", 32'(nondark_cnt), 32'd0);

        $display("step: mid-frame load 1234");
        brightness = 4'd15;
        repeat (40) @(negedge clk);
        do_load(16'h1234, 4'h0, 4'h0);
        wait_ft("dbuf_frame_tick");
        @(negedge clk);
        check("dbuf_first_an",   32'(an),   32'hE);
        check("dbuf_first_segs", 32'(segs), 32'h66);

        $display("step: load coinciding with frame_end");
        repeat (FRAME - 2) @(negedge clk);
        do_load(16'h5678, 4'h0, 4'h0);
        check("coincide_tick", 32'(frame_tick), 32'd1);
        @(negedge clk);
        check("coincide_an",   32'(an),   32'hE);
        check("coincide_segs", 32'(segs), 32'hFE);

        $display("step: blank digit 2, dp digit 0");
        do_load(16'h8421, 4'b0001, 4'b0100);
        wait_ft("blank_frame_tick");
        sample_frame();
        check("blank_digit2_low", 32'(low_cnt[2]), 32'd0);
        check("dp_digit0_cycles", 32'(dp0_cnt),    32'd30);

        $display("step: reset during digit 2 with pending load");
        do_load(16'hFFFF, 4'h0, 4'h0);
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_an",   32'(an),   32'hF);
        check("midreset_segs", 32'(segs), 32'h0);
        rst_n = 1'b1;
        wait_ft("post_reset_tick");
        @(negedge clk);
        check("pending_discard_an",   32'(an),   32'hE);
        check("pending_discard_segs", 32'(segs), 32'hFC);

`ifdef LEAD_ZERO_BLANK_EN
        $display("step: leading-zero blanking 0070");
        do_load(16'h0070, 4'h0, 4'h0);
        wait_ft("lz_frame_tick");
        sample_frame();
        check("lz_digit3_low", 32'(low_cnt[3]), 32'd0);
        check("lz_digit2_low", 32'(low_cnt[2]), 32'd0);
        check("lz_digit1_low", 32'(low_cnt[1]), 32'd30);
        check("lz_digit0_low", 32'(low_cnt[0]), 32'd30);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised, time-multiplexed seven-segment display driver for N common-anode digits. It scans the digits in turn and applies per-digit decimal point and blanking. Brightness is PWM-controlled, and a new display value is double-buffered so it only takes effect at a frame boundary, which prevents tearing. It sits between board-level numeric producers (counters, debug registers) and the display pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal 1..16
- DIV, 25000, clk cycles per PWM phase; legal ≥1; one digit slot = 16·DIV cycles

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- value  in  4·NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = least significant, rightmost)
- dp  in  NUM_DIGITS  decimal-point enable per digit; latched with value
- blank  in  NUM_DIGITS  force digit dark; latched with value
- load  in  1  one-cycle strobe; captures value/dp/blank into the shadow register
- brightness  in  4  duty 0..15; sampled live
- an  out  NUM_DIGITS  anode enables, active-low
- segs  out  8  {a,b,c,d,e,f,g,dp}, active-high
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- Prescaler counts 0..DIV-1 and emits phase_step at DIV-1.
- phase (4 bit) advances on phase_step and wraps at 15 → 0. The wrap is slot_end.
- idx advances on slot_end and wraps at NUM_DIGITS-1 → 0. The wrap is frame_end.
- Shadow register: when load=1, value/dp/blank are captured and pending is set.
- On frame_end with pending=1: the display register takes the shadow contents and pending clears.
- If load and frame_end coincide, the newly presented value goes directly to the display register and pending stays 0.
- Active digit is idx. an[idx]=0 only when phase < brightness and blank[idx]=0. All other an bits are 1.
  - brightness 0 means dark.
  - brightness 15 means 15/16 duty. The guaranteed dark phase 15 is the anti-ghosting interval.
- segs = decode(nibble[idx]) with dp[idx] in bit 0. segs is forced to 0 whenever the digit is dark.
- Decode is the standard hex pattern. Examples: 0→8'hFC, 1→8'h60, 8→8'hFE, F→8'h8E (dp bit excluded).
- Width rules:
  - prescaler is $clog2(DIV) bits, minimum 1.
  - idx is $clog2(NUM_DIGITS) bits, minimum 1.
  - Compares are unsigned.
  - With NUM_DIGITS=1, idx stays 0 and every slot_end is also frame_end.
  - With DIV=1, phase_step is asserted every cycle.

## Timing
- Reset (rst_n=0 at posedge) sets:
  - prescaler, phase, idx = 0
  - display register, shadow register, pending = 0
  - an = all 1, segs = 0, frame_tick = 0
- Reset takes priority over load. A load in the reset cycle is lost.
- an, segs and frame_tick are registered: they reflect counter state with 1-cycle latency.
- frame_tick is high for exactly one cycle, in the cycle after the frame_end counter transition.
- The first display-register update after a load appears on an/segs one cycle after frame_end.
- Worst-case load-to-display latency is NUM_DIGITS·16·DIV + 1 cycles.
- Back-to-back loads before a frame_end: the last one wins.
- brightness changes take effect on the next cycle's compare, with no glitch beyond the registered output.

## Configuration
- LEAD_ZERO_BLANK_EN defined:
  - Digits above the highest non-zero nibble are dark, evaluated on the display register.
  - Digit 0 is never suppressed.
  - A digit with dp=1 stops the suppression at and below it.
- Undefined: all zero nibbles display "0". No extra logic.

## Structure
- Package seg_scan_pkg holds:
  - localparam PWM_STEPS=16
  - the segment-pattern constants for 0..F
  - typedef seg_t (logic [7:0])
- One combinational sub-module, seg_hex_decode: 4-bit nibble in, 7-bit pattern out.
- Counters, buffering, PWM and leading-zero logic stay in seg_scan_mux.

## Test plan
- Reset and scan (NUM_DIGITS=4, DIV=2, brightness=15):
  - Release reset, then load value=16'h8421.
  - an shows the sequence 1110/1101/1011/0111, each on for 30 of 32 cycles.
  - segs patterns match 1,2,4,8.
  - frame_tick pulses every 128 cycles.
- Brightness:
  - brightness=4 → each digit's an is low for exactly 8 cycles per 32-cycle slot.
  - brightness=0 → an stays 4'b1111 and segs=0 for a full frame.
- Double buffering:
  - load 16'h1234 mid-frame.
  - The display keeps the old value until frame_tick; the new value appears on the next cycle with no mixed frame.
  - Also cover load coinciding with frame_end.
- Blank/dp:
  - blank=4'b0100, dp=4'b0001.
  - Digit 2 stays dark; digit 0 segs bit 0 = 1.
- Reset mid-operation:
  - Assert rst_n=0 during digit 2 with pending=1.
  - The next cycle shows an=4'b1111, segs=0, and pending is discarded.
- Leading-zero blanking (LEAD_ZERO_BLANK_EN): value=16'h0070 → digits 3 and 2 are dark, digit 1 shows 7, digit 0 shows 0.
